ysyx_bus_arbiter: RTL and testbench
===================================

// Module: ysyx_bus_arbiter
// PURPOSE
//  Shares the core's single memory bus master between the IFU L1I refill path and the LSU.
//  Owns one simplified AXI master: AR/R, AW/W/B.
//  Grants LSU by priority, honours the IFU lock for multi-beat line fills, bounds IFU starvation.
//  Drops IFU read data that returns after a pipeline flush.
// PARAMETERS
//  XLEN        32  data/address width
//  STARVE_MAX  4   consecutive LSU grants with IFU pending before IFU is forced next
// PORTS
//  clock            in   1     single clock
//  reset            in   1     synchronous, active-high
//  flush_pipeline   in   1     IFU fetch squash
//  ifu_araddr       in   XLEN  IFU read address
//  ifu_arvalid      in   1     IFU read request
//  ifu_lock         in   1     IFU keeps ownership across beats
//  bus_ifu_ready    out  1     IFU request is accepted this cycle
//  ifu_rdata        out  XLEN  IFU read data
//  ifu_rvalid       out  1     IFU read data valid, 1-cycle pulse
//  lsu_araddr       in   XLEN  LSU read address
//  lsu_arvalid      in   1     LSU read request
//  lsu_awaddr       in   XLEN  LSU write address
//  lsu_awvalid      in   1     LSU write request
//  lsu_wdata        in   XLEN  LSU write data
//  lsu_wstrb        in   XLEN/8  LSU byte strobes
//  lsu_ready        out  1     LSU request is accepted this cycle
//  lsu_rdata        out  XLEN  LSU read data
//  lsu_rvalid       out  1     LSU read data valid, 1-cycle pulse
//  lsu_bvalid       out  1     LSU write done, 1-cycle pulse
//  out_araddr, out_arvalid  out  XLEN,1  master AR channel
//  arready          in   1     master AR accept
//  rdata            in   XLEN  master read data
//  rresp            in   2     master read response
//  rvalid           in   1     master read valid
//  out_awaddr, out_awvalid  out  XLEN,1  master AW channel
//  out_wdata, out_wstrb, out_wvalid  out  XLEN,XLEN/8,1  master W channel
//  awready, wready  in   1     master AW/W accept
//  bresp            in   2     master write response
//  bvalid           in   1     master write valid
//  out_rready, out_bready  out  1  master R/B ready
//  out_bus_err      out  1     non-zero rresp/bresp, 1-cycle pulse
// BEHAVIOUR
//  Reset: state=IDLE, starve_cnt=0, drop=0, all outputs 0 except out_rready=out_bready=1.
//  FSM states: IDLE, IFU_AR, IFU_R, IFU_HOLD, LSU_AR, LSU_R, LSU_W, LSU_B.
//  IDLE grant order:
//   1. IFU if ifu_arvalid && starve_cnt==STARVE_MAX.
//   2. Else LSU read.
//   3. Else LSU write.
//   4. Else IFU read.
//  Grant effects: the accept strobe (bus_ifu_ready or lsu_ready) is high that cycle; address/data latch; next state *_AR or LSU_W.
//  Latency: request at cycle N; out_*valid registered high at N+1; held until the matching ready.
//  LSU_W: awvalid and wvalid are driven together. Each drops independently on its own ready. Both done -> LSU_B.
//  R or B handshake:
//   - rdata is forwarded to the owner with *valid pulsed the same cycle (combinational pass-through).
//   - out_bus_err pulses if the resp is non-zero.
//   - Data is delivered regardless of error.
//  IFU_R completion: ifu_lock=1 -> IFU_HOLD; ifu_lock=0 -> IDLE.
//  IFU_HOLD:
//   - bus_ifu_ready=1. ifu_arvalid -> latch, go to IFU_AR.
//   - ifu_lock=0 -> IDLE. LSU stays blocked.
//  starve_cnt:
//   - +1 on an LSU grant while ifu_arvalid=1 (saturates at STARVE_MAX).
//   - Cleared on any IFU grant or when ifu_arvalid=0 in IDLE.
//  flush_pipeline:
//   - In IFU_AR or IFU_R, sets drop. The AR handshake still completes (no valid withdrawal).
//   - R is consumed with ifu_rvalid suppressed. drop clears on R.
//   - Next state is IDLE even if ifu_lock=1.
//   - In IFU_HOLD -> IDLE. Flush has no effect on LSU states.
//  Simultaneous: flush on the same cycle as IFU rvalid -> that data is dropped.
//  Reset mid-operation: immediate return to IDLE. The SoC shares reset, so no in-flight response survives.
// STRUCTURE
//  Shared package ysyx_pkg: state enum ysyx_arb_state_t, AXI resp constants (OKAY=2'b00).
//  One sub-module, ysyx_bus_arb_pick: grant selection plus starve_cnt (~40 lines).
//  FSM and datapath latches are inline.
// TESTING
//  1. IFU read 0x8000_0000, arready at +2, rdata=0x0000_0013 at +4 -> ifu_rvalid=1 with 0x13. LSU untouched.
//  2. IFU and LSU read requested the same cycle -> LSU granted first. IFU AR issues the cycle after lsu_rvalid.
//  3. LSU write 0x0F00_0000 / 0xDEAD_BEEF / wstrb=0xF, awready 2 cycles before wready -> out_wvalid held until wready. One lsu_bvalid.
//  4. ifu_lock=1 over 4 beats with lsu_arvalid asserted throughout -> no LSU AR until lock drops. Then LSU granted.
//  5. LSU requests back-to-back with ifu_arvalid held -> IFU granted after exactly 4 LSU grants.
//  6. flush_pipeline during IFU_R -> ifu_rvalid stays 0 for that beat. Next grant follows the IDLE order.
//  7. rresp=2'b10 on an LSU read -> lsu_rvalid=1 and out_bus_err=1 on the same cycle.

Source files
------------

// File: rtl/ysyx_pkg.sv
// Shared types and constants for the ysyx memory-bus arbiter.
package ysyx_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IFU_AR,
    ST_IFU_R,
    ST_IFU_HOLD,
    ST_LSU_AR,
    ST_LSU_R,
    ST_LSU_W,
    ST_LSU_B
  } ysyx_arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IFU,
    GNT_LSU_RD,
    GNT_LSU_WR
  } ysyx_grant_t;

  function automatic logic resp_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/ysyx_bus_arbiter_if.sv
// IFU, LSU and AXI-master signal bundle; master is the arbiter's view, slave the environment's.
interface ysyx_bus_arbiter_if;
  import ysyx_pkg::*;

  logic              flush_pipeline;
  logic [XLEN-1:0]   ifu_araddr;
  logic              ifu_arvalid;
  logic              ifu_lock;
  logic              bus_ifu_ready;
  logic [XLEN-1:0]   ifu_rdata;
  logic              ifu_rvalid;

  logic [XLEN-1:0]   lsu_araddr;
  logic              lsu_arvalid;
  logic [XLEN-1:0]   lsu_awaddr;
  logic              lsu_awvalid;
  logic [XLEN-1:0]   lsu_wdata;
  logic [STRB_W-1:0] lsu_wstrb;
  logic              lsu_ready;
  logic [XLEN-1:0]   lsu_rdata;
  logic              lsu_rvalid;
  logic              lsu_bvalid;

  logic [XLEN-1:0]   out_araddr;
  logic              out_arvalid;
  logic              arready;
  logic [XLEN-1:0]   rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic [XLEN-1:0]   out_awaddr;
  logic              out_awvalid;
  logic [XLEN-1:0]   out_wdata;
  logic [STRB_W-1:0] out_wstrb;
  logic              out_wvalid;
  logic              awready;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              out_rready;
  logic              out_bready;
  logic              out_bus_err;

  modport master (
    input  flush_pipeline, ifu_araddr, ifu_arvalid, ifu_lock,
    output bus_ifu_ready, ifu_rdata, ifu_rvalid,
    input  lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb,
    output lsu_ready, lsu_rdata, lsu_rvalid, lsu_bvalid,
    output out_araddr, out_arvalid, out_awaddr, out_awvalid, out_wdata, out_wstrb, out_wvalid,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    output out_rready, out_bready, out_bus_err
  );

  modport slave (
    output flush_pipeline, ifu_araddr, ifu_arvalid, ifu_lock,
    input  bus_ifu_ready, ifu_rdata, ifu_rvalid,
    output lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb,
    input  lsu_ready, lsu_rdata, lsu_rvalid, lsu_bvalid,
    input  out_araddr, out_arvalid, out_awaddr, out_awvalid, out_wdata, out_wstrb, out_wvalid,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    input  out_rready, out_bready, out_bus_err
  );

endinterface

// File: rtl/ysyx_bus_arb_pick.sv
// IDLE grant selection with a saturating IFU-starvation counter.
module ysyx_bus_arb_pick
  import ysyx_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        idle_i,
  input  logic        ifu_hold_acc_i,
  input  logic        ifu_arvalid_i,
  input  logic        lsu_arvalid_i,
  input  logic        lsu_awvalid_i,
  output ysyx_grant_t grant_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             starved_s;
  logic             lsu_gnt_s;

  assign starved_s = (starve_cnt_q == CNT_MAX);
  assign lsu_gnt_s = (grant_o == GNT_LSU_RD) || (grant_o == GNT_LSU_WR);

  // Fixed priority: starved IFU, LSU read, LSU write, IFU read.
  always_comb begin
    grant_o = GNT_NONE;
    if (!idle_i) begin
      grant_o = GNT_NONE;
    end else if (ifu_arvalid_i && starved_s) begin
      grant_o = GNT_IFU;
    end else if (lsu_arvalid_i) begin
      grant_o = GNT_LSU_RD;
    end else if (lsu_awvalid_i) begin
      grant_o = GNT_LSU_WR;
    end else if (ifu_arvalid_i) begin
      grant_o = GNT_IFU;
    end else begin
      grant_o = GNT_NONE;
    end
  end

  // Count LSU wins over a waiting IFU; any IFU win or an idle IFU resets it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ifu_hold_acc_i || (grant_o == GNT_IFU)) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (idle_i && !ifu_arvalid_i) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (lsu_gnt_s && ifu_arvalid_i && !starved_s) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_bus_arbiter.sv
// Shares one simplified AXI master between IFU line refills and the LSU,
// with IFU lock, bounded IFU starvation and flush-driven read-data dropping.
module ysyx_bus_arbiter
  import ysyx_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic               clock,
  input logic               reset,
  ysyx_bus_arbiter_if.master bus
);

  ysyx_arb_state_t   state_q;
  logic [XLEN-1:0]   araddr_q;
  logic              arvalid_q;
  logic [XLEN-1:0]   awaddr_q;
  logic              awvalid_q;
  logic [XLEN-1:0]   wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              wvalid_q;
  logic              drop_q;

  ysyx_grant_t grant_s;
  logic        idle_s;
  logic        hold_s;
  logic        hold_acc_s;
  logic        ifu_r_hs_s;
  logic        lsu_r_hs_s;
  logic        lsu_b_hs_s;
  logic        aw_done_s;
  logic        w_done_s;

  assign idle_s     = (state_q == ST_IDLE) && !reset;
  assign hold_s     = (state_q == ST_IFU_HOLD) && !reset && !bus.flush_pipeline;
  assign hold_acc_s = hold_s && bus.ifu_arvalid;
  assign ifu_r_hs_s = (state_q == ST_IFU_R) && bus.rvalid && !reset;
  assign lsu_r_hs_s = (state_q == ST_LSU_R) && bus.rvalid && !reset;
  assign lsu_b_hs_s = (state_q == ST_LSU_B) && bus.bvalid && !reset;
  assign aw_done_s  = !awvalid_q || bus.awready;
  assign w_done_s   = !wvalid_q || bus.wready;

  ysyx_bus_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clock         (clock),
    .reset         (reset),
    .idle_i        (idle_s),
    .ifu_hold_acc_i(hold_acc_s),
    .ifu_arvalid_i (bus.ifu_arvalid),
    .lsu_arvalid_i (bus.lsu_arvalid),
    .lsu_awvalid_i (bus.lsu_awvalid),
    .grant_o       (grant_s)
  );

  // Ownership FSM plus AR/AW/W request registers and the flush drop flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      araddr_q  <= {XLEN{1'b0}};
      arvalid_q <= 1'b0;
      awaddr_q  <= {XLEN{1'b0}};
      awvalid_q <= 1'b0;
      wdata_q   <= {XLEN{1'b0}};
      wstrb_q   <= {STRB_W{1'b0}};
      wvalid_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          case (grant_s)
            GNT_IFU: begin
              araddr_q  <= bus.ifu_araddr;
              arvalid_q <= 1'b1;
              drop_q    <= 1'b0;
              state_q   <= ST_IFU_AR;
            end
            GNT_LSU_RD: begin
              araddr_q  <= bus.lsu_araddr;
              arvalid_q <= 1'b1;
              state_q   <= ST_LSU_AR;
            end
            GNT_LSU_WR: begin
              awaddr_q  <= bus.lsu_awaddr;
              wdata_q   <= bus.lsu_wdata;
              wstrb_q   <= bus.lsu_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_LSU_W;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
        ST_IFU_AR: begin
          // A flush cannot withdraw AR; remember to discard the returning beat.
          if (bus.flush_pipeline) begin
            drop_q <= 1'b1;
          end
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_IFU_R;
          end
        end
        ST_IFU_R: begin
          if (bus.rvalid) begin
            drop_q  <= 1'b0;
            state_q <= (bus.ifu_lock && !bus.flush_pipeline && !drop_q) ? ST_IFU_HOLD : ST_IDLE;
          end else if (bus.flush_pipeline) begin
            drop_q <= 1'b1;
          end
        end
        ST_IFU_HOLD: begin
          if (bus.flush_pipeline) begin
            state_q <= ST_IDLE;
          end else if (bus.ifu_arvalid) begin
            araddr_q  <= bus.ifu_araddr;
            arvalid_q <= 1'b1;
            state_q   <= ST_IFU_AR;
          end else if (!bus.ifu_lock) begin
            state_q <= ST_IDLE;
          end
        end
        ST_LSU_AR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_LSU_R;
          end
        end
        ST_LSU_R: begin
          if (bus.rvalid) begin
            state_q <= ST_IDLE;
          end
        end
        ST_LSU_W: begin
          if (bus.awready) begin
            awvalid_q <= 1'b0;
          end
          if (bus.wready) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            state_q <= ST_LSU_B;
          end
        end
        ST_LSU_B: begin
          if (bus.bvalid) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.bus_ifu_ready = (idle_s && (grant_s == GNT_IFU)) || hold_s;
  assign bus.lsu_ready     = idle_s && ((grant_s == GNT_LSU_RD) || (grant_s == GNT_LSU_WR));

  assign bus.ifu_rdata  = bus.rdata;
  assign bus.ifu_rvalid = ifu_r_hs_s && !drop_q && !bus.flush_pipeline;
  assign bus.lsu_rdata  = bus.rdata;
  assign bus.lsu_rvalid = lsu_r_hs_s;
  assign bus.lsu_bvalid = lsu_b_hs_s;

  assign bus.out_araddr  = araddr_q;
  assign bus.out_arvalid = arvalid_q;
  assign bus.out_awaddr  = awaddr_q;
  assign bus.out_awvalid = awvalid_q;
  assign bus.out_wdata   = wdata_q;
  assign bus.out_wstrb   = wstrb_q;
  assign bus.out_wvalid  = wvalid_q;
  assign bus.out_rready  = 1'b1;
  assign bus.out_bready  = 1'b1;

  // Errors are flagged alongside, never instead of, the data/completion pulse.
  assign bus.out_bus_err = ((ifu_r_hs_s || lsu_r_hs_s) && resp_err(bus.rresp))
                        || (lsu_b_hs_s && resp_err(bus.bresp));

endmodule

// File: tb/tb_ysyx_bus_arbiter.sv
// Directed bench for ysyx_bus_arbiter: inputs change 1ns after posedge, outputs checked at negedge.
module tb_ysyx_bus_arbiter;
  import ysyx_pkg::*;

  logic clock;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  ysyx_bus_arbiter_if bus ();

  ysyx_bus_arbiter #(.STARVE_MAX(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  initial begin
    reset = 1'b1;
    bus.flush_pipeline = 1'b0; bus.ifu_araddr = 32'h0; bus.ifu_arvalid = 1'b0; bus.ifu_lock = 1'b0;
    bus.lsu_araddr = 32'h0; bus.lsu_arvalid = 1'b0; bus.lsu_awaddr = 32'h0; bus.lsu_awvalid = 1'b0;
    bus.lsu_wdata = 32'h0; bus.lsu_wstrb = 4'h0;
    bus.arready = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = 2'b00; bus.bvalid = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1; bus.lsu_arvalid = 1'b1; mid();
    chk1("rst_arvalid", bus.out_arvalid, 1'b0);
    chk1("rst_awvalid", bus.out_awvalid, 1'b0);
    chk1("rst_wvalid", bus.out_wvalid, 1'b0);
    chk1("rst_rready", bus.out_rready, 1'b1);
    chk1("rst_bready", bus.out_bready, 1'b1);
    chk1("rst_lsu_ready", bus.lsu_ready, 1'b0);
    chk1("rst_bus_err", bus.out_bus_err, 1'b0);

    // 1: single IFU read
    cyc(); reset = 1'b0; bus.lsu_arvalid = 1'b0;
    bus.ifu_araddr = 32'h8000_0000; bus.ifu_arvalid = 1'b1; mid();
    chk1("t1_ifu_ready", bus.bus_ifu_ready, 1'b1);
    chk1("t1_lsu_ready", bus.lsu_ready, 1'b0);
    cyc(); bus.ifu_arvalid = 1'b0; mid();
    chk1("t1_arvalid_n1", bus.out_arvalid, 1'b1);
    chkw("t1_araddr", bus.out_araddr, 32'h8000_0000);
    cyc(); bus.arready = 1'b1; mid();
    chk1("t1_arvalid_n2", bus.out_arvalid, 1'b1);
    cyc(); bus.arready = 1'b0; mid();
    chk1("t1_arvalid_n3", bus.out_arvalid, 1'b0);
    cyc(); bus.rvalid = 1'b1; bus.rdata = 32'h0000_0013; mid();
    chk1("t1_ifu_rvalid", bus.ifu_rvalid, 1'b1);
    chkw("t1_ifu_rdata", bus.ifu_rdata, 32'h0000_0013);
    chk1("t1_lsu_rvalid", bus.lsu_rvalid, 1'b0);
    cyc(); bus.rvalid = 1'b0; mid();
    chk1("t1_ifu_rvalid_pulse", bus.ifu_rvalid, 1'b0);

    // 2: simultaneous IFU/LSU read, LSU first
    cyc(); bus.ifu_arvalid = 1'b1; bus.ifu_araddr = 32'h8000_0040;
    bus.lsu_arvalid = 1'b1; bus.lsu_araddr = 32'h1000_0000; mid();
    chk1("t2_lsu_ready", bus.lsu_ready, 1'b1);
    chk1("t2_ifu_wait", bus.bus_ifu_ready, 1'b0);
    cyc(); bus.lsu_arvalid = 1'b0; bus.arready = 1'b1; mid();
    chkw("t2_lsu_araddr", bus.out_araddr, 32'h1000_0000);
    cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0055; mid();
    chk1("t2_lsu_rvalid", bus.lsu_rvalid, 1'b1);
    chkw("t2_lsu_rdata", bus.lsu_rdata, 32'h0000_0055);
    chk1("t2_ifu_rvalid", bus.ifu_rvalid, 1'b0);
    cyc(); bus.rvalid = 1'b0; mid();
    chk1("t2_ifu_ready_after", bus.bus_ifu_ready, 1'b1);
    cyc(); bus.ifu_arvalid = 1'b0; bus.arready = 1'b1; mid();
    chkw("t2_ifu_araddr", bus.out_araddr, 32'h8000_0040);
    chk1("t2_ifu_arvalid", bus.out_arvalid, 1'b1);
    cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0077; mid();
    chk1("t2_ifu_rvalid2", bus.ifu_rvalid, 1'b1);
    cyc(); bus.rvalid = 1'b0;

    // 3: LSU write, awready two cycles ahead of wready
    bus.lsu_awvalid = 1'b1; bus.lsu_awaddr = 32'h0F00_0000;
    bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wstrb = 4'hF; mid();
    chk1("t3_lsu_ready", bus.lsu_ready, 1'b1);
    cyc(); bus.lsu_awvalid = 1'b0; bus.awready = 1'b1; mid();
    chk1("t3_awvalid", bus.out_awvalid, 1'b1);
    chk1("t3_wvalid", bus.out_wvalid, 1'b1);
    chkw("t3_awaddr", bus.out_awaddr, 32'h0F00_0000);
    chkw("t3_wdata", bus.out_wdata, 32'hDEAD_BEEF);
    chkw("t3_wstrb", 32'(bus.out_wstrb), 32'h0000_000F);
    cyc(); bus.awready = 1'b0; mid();
    chk1("t3_aw_dropped", bus.out_awvalid, 1'b0);
    chk1("t3_w_held", bus.out_wvalid, 1'b1);
    cyc(); bus.wready = 1'b1; mid();
    chk1("t3_w_held2", bus.out_wvalid, 1'b1);
    cyc(); bus.wready = 1'b0; mid();
    chk1("t3_w_dropped", bus.out_wvalid, 1'b0);
    chk1("t3_no_bvalid_yet", bus.lsu_bvalid, 1'b0);
    cyc(); bus.bvalid = 1'b1; bus.bresp = 2'b00; mid();
    chk1("t3_bvalid", bus.lsu_bvalid, 1'b1);
    chk1("t3_no_err", bus.out_bus_err, 1'b0);
    cyc(); bus.bvalid = 1'b0; mid();
    chk1("t3_bvalid_pulse", bus.lsu_bvalid, 1'b0);

    // 4: locked 4-beat IFU fill blocks a waiting LSU read
    for (int b = 0; b < 4; b++) begin
      cyc(); bus.ifu_arvalid = 1'b1; bus.ifu_araddr = 32'h8000_1000 + 32'(b * 4); bus.ifu_lock = 1'b1; mid();
      chk1("t4_ifu_ready", bus.bus_ifu_ready, 1'b1);
      chk1("t4_lsu_blocked", bus.lsu_ready, 1'b0);
      cyc(); bus.ifu_arvalid = 1'b0; bus.arready = 1'b1;
      bus.lsu_arvalid = 1'b1; bus.lsu_araddr = 32'h2000_0000; mid();
      chkw("t4_araddr", bus.out_araddr, 32'h8000_1000 + 32'(b * 4));
      cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'(b); bus.ifu_lock = (b != 3); mid();
      chk1("t4_ifu_rvalid", bus.ifu_rvalid, 1'b1);
      chk1("t4_lsu_blocked_r", bus.lsu_ready, 1'b0);
    end
    cyc(); bus.rvalid = 1'b0; mid();
    chk1("t4_lsu_after_lock", bus.lsu_ready, 1'b1);
    chk1("t4_ifu_not_ready", bus.bus_ifu_ready, 1'b0);
    cyc(); bus.lsu_arvalid = 1'b0; bus.arready = 1'b1; mid();
    chkw("t4_lsu_araddr", bus.out_araddr, 32'h2000_0000);

    // 7: SLVERR on an LSU read still delivers data
    cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rresp = 2'b10; bus.rdata = 32'hCAFE_F00D; mid();
    chk1("t7_lsu_rvalid", bus.lsu_rvalid, 1'b1);
    chk1("t7_bus_err", bus.out_bus_err, 1'b1);
    chkw("t7_lsu_rdata", bus.lsu_rdata, 32'hCAFE_F00D);
    cyc(); bus.rvalid = 1'b0; bus.rresp = 2'b00; mid();
    chk1("t7_err_pulse", bus.out_bus_err, 1'b0);

    // 5: starvation bound, IFU forced after exactly 4 LSU grants
    cyc(); bus.ifu_arvalid = 1'b1; bus.ifu_araddr = 32'h8000_2000;
    bus.lsu_arvalid = 1'b1; bus.lsu_araddr = 32'h3000_0000;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk1("t5_lsu_ready", bus.lsu_ready, 1'b1);
      chk1("t5_ifu_wait", bus.bus_ifu_ready, 1'b0);
      cyc(); bus.arready = 1'b1; mid();
      chkw("t5_lsu_araddr", bus.out_araddr, 32'h3000_0000);
      cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'(k); mid();
      chk1("t5_lsu_rvalid", bus.lsu_rvalid, 1'b1);
      cyc(); bus.rvalid = 1'b0;
    end
    mid();
    chk1("t5_ifu_forced", bus.bus_ifu_ready, 1'b1);
    chk1("t5_lsu_held", bus.lsu_ready, 1'b0);
    cyc(); bus.ifu_arvalid = 1'b0; bus.arready = 1'b1; mid();
    chkw("t5_ifu_araddr", bus.out_araddr, 32'h8000_2000);
    cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0021; mid();
    chk1("t5_ifu_rvalid", bus.ifu_rvalid, 1'b1);
    cyc(); bus.rvalid = 1'b0; mid();
    chk1("t5_lsu_resumes", bus.lsu_ready, 1'b1);
    cyc(); bus.lsu_arvalid = 1'b0; bus.arready = 1'b1;
    cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1;
    cyc(); bus.rvalid = 1'b0;

    // 6: flush during IFU_R drops the beat and ignores the lock
    bus.ifu_arvalid = 1'b1; bus.ifu_araddr = 32'h8000_3000; bus.ifu_lock = 1'b1; mid();
    chk1("t6_ifu_ready", bus.bus_ifu_ready, 1'b1);
    cyc(); bus.ifu_arvalid = 1'b0; bus.arready = 1'b1;
    cyc(); bus.arready = 1'b0; bus.flush_pipeline = 1'b1;
    cyc(); bus.flush_pipeline = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hBAD0_BAD0; mid();
    chk1("t6_dropped", bus.ifu_rvalid, 1'b0);
    cyc(); bus.rvalid = 1'b0; bus.ifu_lock = 1'b0;
    bus.ifu_arvalid = 1'b1; bus.ifu_araddr = 32'h8000_3040;
    bus.lsu_arvalid = 1'b1; bus.lsu_araddr = 32'h4000_0000; mid();
    chk1("t6_idle_order_lsu", bus.lsu_ready, 1'b1);
    chk1("t6_idle_order_ifu", bus.bus_ifu_ready, 1'b0);
    cyc(); bus.lsu_arvalid = 1'b0; bus.arready = 1'b1;
    cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1;
    cyc(); bus.rvalid = 1'b0; mid();
    chk1("t6_ifu_ready2", bus.bus_ifu_ready, 1'b1);
    cyc(); bus.ifu_arvalid = 1'b0; bus.arready = 1'b1; mid();
    chkw("t6_ifu_araddr", bus.out_araddr, 32'h8000_3040);
    cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0011; bus.flush_pipeline = 1'b1; mid();
    chk1("t6_flush_same_cycle", bus.ifu_rvalid, 1'b0);
    cyc(); bus.rvalid = 1'b0; bus.flush_pipeline = 1'b0;
    bus.ifu_arvalid = 1'b1; bus.ifu_araddr = 32'h8000_3080; mid();
    chk1("t6_ifu_ready3", bus.bus_ifu_ready, 1'b1);
    cyc(); bus.ifu_arvalid = 1'b0; bus.arready = 1'b1;
    cyc(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0099; mid();
    chk1("t6_drop_cleared", bus.ifu_rvalid, 1'b1);
    chkw("t6_rdata", bus.ifu_rdata, 32'h0000_0099);
    cyc(); bus.rvalid = 1'b0;

    // Reset in the middle of a write
    bus.lsu_awvalid = 1'b1; bus.lsu_awaddr = 32'h0F00_0010; mid();
    chk1("rm_lsu_ready", bus.lsu_ready, 1'b1);
    cyc(); bus.lsu_awvalid = 1'b0; reset = 1'b1; mid();
    chk1("rm_awvalid_before", bus.out_awvalid, 1'b1);
    cyc(); mid();
    chk1("rm_awvalid_cleared", bus.out_awvalid, 1'b0);
    chk1("rm_wvalid_cleared", bus.out_wvalid, 1'b0);
    cyc(); reset = 1'b0; mid();
    chk1("rm_idle_quiet", bus.out_arvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
